flash_rom_controller: RTL and testbench
=======================================

Name: flash_rom_controller

Overview:
- Responder end of the ROM request interface (addr/load/byte -> data/ready) that the ROM arbiter drives.
- Accepts one read request at a time and runs a timed asynchronous read cycle on the parallel NOR flash pins.
- Returns a zero-extended byte or a full word, and holds it stable until the next completed read.
- Sits between the ROM arbiter and the board flash device; read-only (no program/erase).

Parameters:
- WIDTH, 16, data width of the interface and of the flash data bus.
- ROM_ADDR, 24, address width.
- ACCESS_CYCLES, 6, clk cycles for which CE/OE are held before sampling (>=1; 6 covers 110 ns at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  ROM_ADDR  read address; sampled with load.
- load  in  1  request strobe; honoured only while ready=1.
- byte  in  1  1 = byte read, 0 = word read; sampled with load.
- ready  out  1  1 = idle, data valid, next load accepted.
- data  out  WIDTH  read result.
- flash_addr  out  ROM_ADDR  registered address to the device.
- flash_data  in  WIDTH  device data bus (read-only).
- flash_ce_n  out  1  chip enable, active low.
- flash_oe_n  out  1  output enable, active low.
- flash_we_n  out  1  write enable; constant 1.
- flash_byte_n  out  1  0 = x8 mode, 1 = x16 mode.
- flash_rp_n  out  1  device reset, active low; registered ~rst.

Behaviour:
- States: IDLE, ACCESS, RECOVER. Reset -> IDLE.
- Reset values:
  - ready=1, data=0, flash_addr=0.
  - flash_ce_n=1, flash_oe_n=1, flash_byte_n=1, flash_rp_n=0.
  - Counter=0.
- IDLE:
  - ready=1; strobes deasserted.
  - load=1 at an edge: latch addr into flash_addr and ~byte into flash_byte_n, load counter=ACCESS_CYCLES-1, drive ce_n=oe_n=0, go to ACCESS, ready=0. All of these are registered at that same edge.
- ACCESS:
  - Each edge: if counter!=0, decrement.
  - If counter==0: capture data; drive ce_n=oe_n=1; go to RECOVER.
  - Strobes are therefore low for exactly ACCESS_CYCLES cycles.
- Capture rules:
  - Byte: data = {zeros, flash_data[7:0]}.
  - Word: data = flash_data.
- RECOVER:
  - One cycle with strobes high (bus turnaround); next edge -> IDLE with ready=1.
- Timing:
  - Load-sampling edge = E0. Capture at edge E0+ACCESS_CYCLES; ready rises at edge E0+ACCESS_CYCLES+1.
  - Back-to-back throughput: one read per ACCESS_CYCLES+2 cycles.
- load while ready=0 is ignored (not queued); addr/byte may change freely during ACCESS.
- data holds its last captured value through later ACCESS/RECOVER cycles and changes only at a capture edge or reset.
- flash_addr and flash_byte_n hold their values after completion until the next accepted load.
- flash_we_n is tied to 1 in all states.
- Reset mid-operation: next edge forces IDLE and all reset values, including data=0; no capture occurs.
- flash_rp_n=0 while rst=1, and 1 from the first edge after rst falls.
- rst and load at the same edge: reset wins; the request is dropped.
- ACCESS_CYCLES=1: a single ACCESS cycle; ready rises at E0+2.
- Counter width: $clog2(ACCESS_CYCLES) with a minimum of 1 bit.

Decomposition:
- Shared ROM package holds:
  - state encoding (IDLE/ACCESS/RECOVER);
  - default ROM_ADDR/WIDTH constants;
  - the byte zero-extension function.
  These are shared with the ROM arbiter.
- One natural sub-module: rom_access_timer, a loadable down-counter with a zero flag, reusable for later write/erase timing. Everything else stays in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles -> ready=1, data=0, ce_n=oe_n=we_n=1, rp_n=0; rp_n=1 one edge after release.
- Word read, ACCESS_CYCLES=4: load with addr=24'h000010, byte=0, flash model drives 16'hBEEF -> ce_n/oe_n low for exactly 4 cycles; data=16'hBEEF at E0+4; ready=1 at E0+5.
- Byte read: addr=24'h000011, byte=1, model drives 16'h12A5 -> flash_byte_n=0 during access; data=16'h00A5.
- Busy-load ignored: pulse load with addr=24'h000020 two cycles after an accepted load to 24'h000010 -> flash_addr stays 24'h000010; exactly one read occurs; no second read starts.
- Back-to-back: load reasserted the cycle ready rises, to 24'h000030 then 24'h000032 -> second E0 is 6 cycles after the first (ACCESS_CYCLES+2); strobes are high for at least 1 cycle between reads.
- Reset mid-ACCESS: assert rst at counter=2 -> next edge: IDLE, ready=1, data=0, strobes high; the old flash_data is never captured.

Source files
------------

// File: rtl/flash_rom_controller_pkg.sv
// Shared ROM definitions: read-cycle state encoding, default bus sizes,
// byte zero-extension and timer width helper. The ROM arbiter uses these too.
package flash_rom_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } romState_t;

    localparam int ROM_ADDR_DEFAULT = 24;
    localparam int WIDTH_DEFAULT    = 16;

    // Widest data bus any ROM client uses; callers cast down to their width.
    localparam int EXT_MAX_WIDTH    = 64;

    // Zero-extend a byte read so clients never see stale upper lanes.
    function automatic logic [EXT_MAX_WIDTH-1:0] zeroExtendByte(input logic [7:0] b);
        return {{(EXT_MAX_WIDTH-8){1'b0}}, b};
    endfunction

    // Down-counter width able to hold cycles-1, never narrower than one bit.
    function automatic int counterWidth(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/flash_rom_controller_timer.sv
// Loadable down-counter with a zero flag; times flash access windows and is
// meant to be reused for program/erase pulse timing later.
module rom_access_timer
    import flash_rom_controller_pkg::*;
#(
    parameter int CYCLES = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             enable,
    input  logic [counterWidth(CYCLES)-1:0]  loadValue,
    output logic                             zero
);

    localparam int CW = counterWidth(CYCLES);

    logic [CW-1:0] count;

    // Load wins over counting; counting stops at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/flash_rom_controller.sv
// Read-only parallel NOR flash responder for the ROM arbiter: one timed
// asynchronous read per accepted request, result held until the next read.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready, strobes high, waiting for load
//   ACCESS  | CE/OE low, timer counting down; capture at terminal count
//   RECOVER | one bus-turnaround cycle with strobes high
//
// byteRead is the request's byte/word select (1 = byte read).
module flash_rom_controller
    import flash_rom_controller_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int ROM_ADDR      = ROM_ADDR_DEFAULT,
    parameter int ACCESS_CYCLES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ROM_ADDR-1:0] addr,
    input  logic                load,
    input  logic                byteRead,
    output logic                ready,
    output logic [WIDTH-1:0]    data,
    output logic [ROM_ADDR-1:0] flash_addr,
    input  logic [WIDTH-1:0]    flash_data,
    output logic                flash_ce_n,
    output logic                flash_oe_n,
    output logic                flash_we_n,
    output logic                flash_byte_n,
    output logic                flash_rp_n
);

    localparam int CW = counterWidth(ACCESS_CYCLES);

    romState_t state, nextState;
    logic      timerLoad;
    logic      timerEnable;
    logic      timerZero;
    logic      capture;

    rom_access_timer #(
        .CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timerLoad),
        .enable   (timerEnable),
        .loadValue(CW'(ACCESS_CYCLES - 1)),
        .zero     (timerZero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        nextState   = state;
        timerLoad   = 1'b0;
        timerEnable = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    timerLoad = 1'b1;
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (timerZero) begin
                    capture   = 1'b1;
                    nextState = RECOVER;
                end else begin
                    timerEnable = 1'b1;
                end
            end
            RECOVER: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Registered flash pins and read result; strobes follow the next state so
    // they are low exactly while the FSM sits in ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            data         <= '0;
            flash_addr   <= '0;
            flash_ce_n   <= 1'b1;
            flash_oe_n   <= 1'b1;
            flash_byte_n <= 1'b1;
            flash_rp_n   <= 1'b0;
        end else begin
            flash_rp_n <= 1'b1;
            flash_ce_n <= (nextState != ACCESS);
            flash_oe_n <= (nextState != ACCESS);
            if (timerLoad) begin
                flash_addr   <= addr;
                flash_byte_n <= ~byteRead;
            end
            if (capture) begin
                data <= flash_byte_n ? flash_data
                                     : WIDTH'(zeroExtendByte(flash_data[7:0]));
            end
        end
    end

    assign ready      = (state == IDLE);
    assign flash_we_n = 1'b1;

endmodule

// File: tb/tb_flash_rom_controller.sv
// Bench for flash_rom_controller: directed cases plus randomized reads with
// busy-time load noise, checked against a per-request timing/data model.
module tb_flash_rom_controller;

    localparam int AC = 4;
    localparam int W  = 16;
    localparam int A  = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic [A-1:0] addr;
    logic         load;
    logic         byteRead;
    logic         ready;
    logic [W-1:0] data;
    logic [A-1:0] flash_addr;
    logic [W-1:0] flash_data;
    logic         flash_ce_n;
    logic         flash_oe_n;
    logic         flash_we_n;
    logic         flash_byte_n;
    logic         flash_rp_n;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [W-1:0] expData;

    flash_rom_controller #(
        .WIDTH(W),
        .ROM_ADDR(A),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .load        (load),
        .byteRead    (byteRead),
        .ready       (ready),
        .data        (data),
        .flash_addr  (flash_addr),
        .flash_data  (flash_data),
        .flash_ce_n  (flash_ce_n),
        .flash_oe_n  (flash_oe_n),
        .flash_we_n  (flash_we_n),
        .flash_byte_n(flash_byte_n),
        .flash_rp_n  (flash_rp_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Flash device contents: fixed test-plan words plus an address hash.
    function automatic logic [W-1:0] romValue(input logic [A-1:0] a);
        if (a == 24'h000010) return 16'hBEEF;
        if (a == 24'h000011) return 16'h12A5;
        return {a[7:0] ^ 8'h3C, a[15:8] ^ a[23:16] ^ a[7:0] ^ 8'hA5};
    endfunction

    // Bus floats to all-ones when output enable is off.
    assign flash_data = flash_oe_n ? 16'hFFFF : romValue(flash_addr);

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ready !== 1'b1) checkEq("readyTimeout", ready, 1);
    endtask

    // One read: request, AC strobe cycles, capture, recover. noiseAt (1..AC)
    // pulses load with noiseAddr during the busy window; 0 means none.
    task automatic doRead(input logic [A-1:0] a, input logic b, input int noiseAt,
                          input logic [A-1:0] noiseAddr, output int e0);
        logic [W-1:0] word;
        logic [W-1:0] want;
        logic         byteN;
        word  = romValue(a);
        want  = b ? {8'h00, word[7:0]} : word;
        byteN = !b;
        waitReady();
        addr     = a;
        byteRead = b;
        load     = 1'b1;
        tick();
        e0       = cycle;
        load     = 1'b0;
        addr     = A'($urandom);
        byteRead = 1'($urandom);
        for (int k = 1; k <= AC; k++) begin
            checkEq("ceLow",    flash_ce_n, 0);
            checkEq("oeLow",    flash_oe_n, 0);
            checkEq("busy",     ready, 0);
            checkEq("addrHeld", flash_addr, a);
            checkEq("byteN",    flash_byte_n, byteN);
            checkEq("dataHeld", data, expData);
            if (k == noiseAt) begin
                load = 1'b1;
                addr = noiseAddr;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load    = 1'b0;
        expData = want;
        checkEq("capture",     data, want);
        checkEq("ceRecover",   flash_ce_n, 1);
        checkEq("oeRecover",   flash_oe_n, 1);
        checkEq("recoverBusy", ready, 0);
        tick();
        checkEq("readyBack", ready, 1);
        checkEq("dataKeep",  data, want);
        checkEq("addrKeep",  flash_addr, a);
        checkEq("weHigh",    flash_we_n, 1);
    endtask

    initial begin
        int e0a, e0b;
        rst      = 1'b1;
        load     = 1'b0;
        addr     = '0;
        byteRead = 1'b0;
        expData  = '0;

        // Reset state.
        repeat (3) tick();
        checkEq("rstReady", ready, 1);
        checkEq("rstData",  data, 0);
        checkEq("rstCe",    flash_ce_n, 1);
        checkEq("rstOe",    flash_oe_n, 1);
        checkEq("rstWe",    flash_we_n, 1);
        checkEq("rstByteN", flash_byte_n, 1);
        checkEq("rstAddr",  flash_addr, 0);
        checkEq("rstRp",    flash_rp_n, 0);
        rst = 1'b0;
        tick();
        checkEq("rpRelease", flash_rp_n, 1);

        // Word read, then byte read.
        doRead(24'h000010, 1'b0, 0, '0, e0a);
        checkEq("wordBeef", data, 16'hBEEF);
        doRead(24'h000011, 1'b1, 0, '0, e0a);
        checkEq("byteA5", data, 16'h00A5);

        // Load during busy is dropped; no second read follows.
        doRead(24'h000010, 1'b0, 2, 24'h000020, e0a);
        for (int i = 0; i < 4; i++) begin
            checkEq("noSecondCe", flash_ce_n, 1);
            checkEq("noSecondRdy", ready, 1);
            tick();
        end
        checkEq("busyAddrKept", flash_addr, 24'h000010);

        // Back-to-back reads: new load in the cycle ready rises.
        doRead(24'h000030, 1'b0, 0, '0, e0a);
        doRead(24'h000032, 1'b0, 0, '0, e0b);
        checkEq("b2bSpacing", e0b - e0a, AC + 2);

        // Reset during ACCESS with the counter at 2.
        addr     = 24'h000040;
        byteRead = 1'b0;
        load     = 1'b1;
        tick();
        load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        expData = '0;
        checkEq("midRstReady", ready, 1);
        checkEq("midRstData",  data, 0);
        checkEq("midRstCe",    flash_ce_n, 1);
        checkEq("midRstOe",    flash_oe_n, 1);
        checkEq("midRstAddr",  flash_addr, 0);
        checkEq("midRstRp",    flash_rp_n, 0);
        rst = 1'b0;
        for (int i = 0; i < AC + 2; i++) begin
            tick();
            checkEq("noLateCapture", data, 0);
            checkEq("idleAfterRst",  flash_ce_n, 1);
        end

        // Reset and load at the same edge: request dropped.
        rst  = 1'b1;
        load = 1'b1;
        addr = 24'h000077;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        checkEq("rstLoadReady", ready, 1);
        checkEq("rstLoadCe",    flash_ce_n, 1);
        checkEq("rstLoadAddr",  flash_addr, 0);
        tick();
        checkEq("rstLoadStill", flash_ce_n, 1);

        // Randomized reads with random gaps and busy-time noise.
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
            doRead(A'($urandom), 1'($urandom), int'($urandom_range(0, AC)),
                   A'($urandom), e0a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
